// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types, default 640x480@60 timing and RGB332 expansion
// No ports. Imported by vga_timing_gen and vga_frame_reader.
// Build option used by importers: VGA_UPSCALE2X_EN (2x pixel doubling).
package vga_pkg;

  // Default 640x480 timing, horizontal in pixels, vertical in lines.
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Counter width covers totals up to 4095 pixels / lines.
  localparam int CNT_W = 12;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb888_t;

  // Control bits carried alongside the memory read so they line up with q_IO.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic frame_start;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0, frame_start: 1'b0};

  // Bit replication spreads each channel over the full 8-bit range,
  // so all-zeros maps to 0x00 and all-ones maps to 0xFF.
  function automatic rgb888_t expand_rgb332(input rgb332_t p);
    rgb888_t o;
    o.red   = {p.r, p.r, p.r[2:1]};
    o.green = {p.g, p.g, p.g[2:1]};
    o.blue  = {p.b, p.b, p.b, p.b};
    return o;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel/line counters and raw (undelayed) sync, de, frame_start
// Ports:
//   clk, rst_n (async, active-low), pix_en (pixel-rate strobe)
//   h_cnt, v_cnt        current pixel column / line
//   hsync, vsync        raw active-low sync pulses
//   de                  raw data enable (active area)
//   frame_start         high on the pix_en cycle that processes pixel (0,0)
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame_start
);

  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SBEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SEND = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SBEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SEND = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign hsync       = !((h_cnt >= H_SBEG) && (h_cnt <= H_SEND));
  assign vsync       = !((v_cnt >= V_SBEG) && (v_cnt <= V_SEND));
  assign de          = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign frame_start = pix_en && (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - VGA scan-out reading RGB332 pixels from memory
// Ports:
//   clk, rst_n (async, active-low), pix_en (pixel-rate strobe)
//   address_IO   registered byte address of the pixel being fetched
//   q_IO         RGB332 byte returned by memory MEM_LAT cycles later
//   hsync, vsync active-low syncs, delayed to line up with q_IO
//   red/green/blue expanded colour, zero outside the active area
//   de           delayed data enable
//   frame_start  delayed marker of pixel (0,0)
// Build option: VGA_UPSCALE2X_EN reads a half-resolution buffer and doubles each pixel.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_8000,
  parameter int MEM_LAT  = 2,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  output logic [31:0] address_IO,
  input  logic [7:0]  q_IO,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        de,
  output logic        frame_start
);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  ctl_t             raw;
  ctl_t             pipe [0:MEM_LAT];
  rgb888_t          colour;
  logic [31:0]      src_x;
  logic [31:0]      src_y;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .hsync       (raw.hsync),
    .vsync       (raw.vsync),
    .de          (raw.de),
    .frame_start (raw.frame_start)
  );

`ifdef VGA_UPSCALE2X_EN
  localparam logic [31:0] SRC_W = 32'(H_ACTIVE / 2);
  assign src_x = 32'(h_cnt >> 1);
  assign src_y = 32'(v_cnt >> 1);
`else
  localparam logic [31:0] SRC_W = 32'(H_ACTIVE);
  assign src_x = 32'(h_cnt);
  assign src_y = 32'(v_cnt);
`endif

  // Only active pixels issue a new address; blanking keeps the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address_IO <= BASE_ADDR;
    end else if (pix_en && raw.de) begin
      address_IO <= BASE_ADDR + src_y * SRC_W + src_x;
    end
  end

  // Stage 0 is loaded in the same pix_en cycle as address_IO, so the last
  // stage (MEM_LAT) carries the control bits of the pixel whose colour is
  // being registered in that same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= MEM_LAT; i++) pipe[i] <= CTL_IDLE;
    end else if (pix_en) begin
      pipe[0] <= raw;
      for (int i = 1; i <= MEM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // The colour register is itself the final stage, so it is gated by the
  // de entering the last control stage, not the one leaving it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colour <= '0;
    end else if (pix_en) begin
      colour <= pipe[MEM_LAT-1].de ? expand_rgb332(rgb332_t'(q_IO)) : '0;
    end
  end

  assign hsync       = pipe[MEM_LAT].hsync;
  assign vsync       = pipe[MEM_LAT].vsync;
  assign de          = pipe[MEM_LAT].de;
  assign frame_start = pipe[MEM_LAT].frame_start;
  assign red         = colour.red;
  assign green       = colour.green;
  assign blue        = colour.blue;

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb/tb_vga_frame_reader.sv - directed bench for vga_frame_reader on a reduced 24x12 raster
// No ports. Timing: H 16/2/4/2 (total 24), V 8/1/2/1 (total 12), MEM_LAT 2, BASE 0x8000.
// Honours VGA_UPSCALE2X_EN for the expected addresses and colours.
module tb_vga_frame_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_en;
  logic [31:0] address_IO;
  logic [7:0]  q_IO;
  logic        hsync, vsync, de, frame_start;
  logic [7:0]  red, green, blue;

  int total = 0;
  int bad   = 0;

  logic [31:0] m1, m2;
  logic        ff_mode = 1'b0;

  always #5 clk = ~clk;

  // Memory: two clock cycles of read latency, data = low address byte.
  always @(posedge clk) begin
    m1 <= address_IO;
    m2 <= m1;
  end
  assign q_IO = ff_mode ? 8'hFF : m2[7:0];

  vga_frame_reader #(
    .BASE_ADDR(32'h0000_8000), .MEM_LAT(2),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .address_IO  (address_IO),
    .q_IO        (q_IO),
    .hsync       (hsync),
    .vsync       (vsync),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .de          (de),
    .frame_start (frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic pe);
    @(negedge clk);
    pix_en = pe;
    @(posedge clk);
    #1;
  endtask

  // One pixel period at 25 MHz from 50 MHz: strobe, then idle cycle.
  task automatic step();
    tick(1'b1);
    tick(1'b0);
  endtask

  function automatic logic [31:0] exp_addr(input int h, input int v);
`ifdef VGA_UPSCALE2X_EN
    return 32'h8000 + 32'((v / 2) * 8 + h / 2);
`else
    return 32'h8000 + 32'(v * 16 + h);
`endif
  endfunction

  function automatic logic [23:0] exp_rgb(input logic [7:0] q);
    logic [7:0] r, g, b;
    r = {q[7:5], q[7:5], q[7:6]};
    g = {q[4:2], q[4:2], q[4:3]};
    b = {q[1:0], q[1:0], q[1:0], q[1:0]};
    return {r, g, b};
  endfunction

  task automatic wait_fs(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 10 && !frame_start; i++) begin
      step();
      n++;
    end
    chk(tag, 32'(n), 32'd3);
  endtask

  // Walks one frame starting at the sample showing pixel (0,0) at the outputs.
  task automatic check_frame(input logic ff, input logic set_ff);
    int de_n, hs_low, vs_low, hs_fall, vs_fall;
    logic hs_prev, vs_prev;
    logic de_e, hs_e, vs_e;
    logic [23:0] rgb_e;
    int h, v;
    de_n = 0; hs_low = 0; vs_low = 0; hs_fall = 0; vs_fall = 0;
    hs_prev = 1'b1; vs_prev = 1'b1;
    for (int s = 0; s < 288; s++) begin
      h = s % 24;
      v = s / 24;
      de_e  = (h < 16) && (v < 8);
      hs_e  = !((h >= 18) && (h <= 21));
      vs_e  = !((v >= 9) && (v <= 10));
      rgb_e = !de_e ? 24'h0 : ff ? 24'hFFFFFF : exp_rgb(exp_addr(h, v) & 32'hFF);
      chk("frm_de", 32'(de), 32'(de_e));
      chk("frm_hsync", 32'(hsync), 32'(hs_e));
      chk("frm_vsync", 32'(vsync), 32'(vs_e));
      chk("frm_fs", 32'(frame_start), 32'(s == 0));
      chk("frm_rgb", {8'h0, red, green, blue}, {8'h0, rgb_e});
      if (de) de_n++;
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (hs_prev && !hsync) hs_fall++;
      if (vs_prev && !vsync) vs_fall++;
      hs_prev = hsync;
      vs_prev = vsync;
      if (set_ff && s == 250) ff_mode = 1'b1;
      step();
    end
    chk("frm_de_count", 32'(de_n), 32'd128);
    chk("frm_hs_low", 32'(hs_low), 32'd48);
    chk("frm_hs_pulses", 32'(hs_fall), 32'd12);
    chk("frm_vs_low", 32'(vs_low), 32'd48);
    chk("frm_vs_pulses", 32'(vs_fall), 32'd1);
    chk("frm_next_fs", 32'(frame_start), 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_addr"}, address_IO, 32'h0000_8000);
    chk({tag, "_hsync"}, 32'(hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(vsync), 32'd1);
    chk({tag, "_de"}, 32'(de), 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    chk({tag, "_rgb"}, {8'h0, red, green, blue}, 32'h0);
  endtask

  initial begin
    rst_n  = 1'b0;
    pix_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk_idle("reset");

    @(negedge clk);
    rst_n = 1'b1;
    wait_fs("fs_latency");

    // 3 pixels processed; 75 more -> pixel (5,3) just addressed.
    repeat (75) step();
`ifdef VGA_UPSCALE2X_EN
    chk("addr_5_3", address_IO, 32'h0000_800A);
`else
    chk("addr_5_3", address_IO, 32'h0000_8035);
`endif
    repeat (2) step();
    chk("de_5_3", 32'(de), 32'd1);
`ifdef VGA_UPSCALE2X_EN
    chk("rgb_5_3", {8'h0, red, green, blue}, 32'h0000_49AA);
`else
    chk("rgb_5_3", {8'h0, red, green, blue}, 32'h0024_B655);
`endif

    // Freeze mid-line for 100 clocks.
    repeat (100) tick(1'b0);
`ifdef VGA_UPSCALE2X_EN
    chk("frz_addr", address_IO, 32'h0000_800B);
    chk("frz_rgb", {8'h0, red, green, blue}, 32'h0000_49AA);
`else
    chk("frz_addr", address_IO, 32'h0000_8037);
    chk("frz_rgb", {8'h0, red, green, blue}, 32'h0024_B655);
`endif
    chk("frz_de", 32'(de), 32'd1);
    chk("frz_hsync", 32'(hsync), 32'd1);
    step();
`ifdef VGA_UPSCALE2X_EN
    chk("resume_addr", address_IO, 32'h0000_800C);
`else
    chk("resume_addr", address_IO, 32'h0000_8038);
`endif
    chk("resume_de", 32'(de), 32'd1);

    // Pixel (20,3) is horizontal blanking: address holds (15,3).
    repeat (12) step();
`ifdef VGA_UPSCALE2X_EN
    chk("blank_addr", address_IO, 32'h0000_800F);
`else
    chk("blank_addr", address_IO, 32'h0000_803F);
`endif
    chk("blank_de", 32'(de), 32'd0);
    chk("blank_hsync", 32'(hsync), 32'd0);
    chk("blank_rgb", {8'h0, red, green, blue}, 32'h0);

    // Counters now at (10,5): asynchronous reset between clock edges.
    repeat (37) step();
    chk("pre_rst_de", 32'(de), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    wait_fs("fs_after_rst");

    check_frame(1'b0, 1'b1);
    check_frame(1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
